// File: rtl/reg_arbiter.sv
// reg_arbiter: two-requester arbiter in front of a shared load/increment register.
//
// A winner is picked in IDLE, its op/data are captured, a single load or
// increment strobe is issued in EXEC, and the winner is acknowledged in ACK
// until it drops its request (four-phase handshake).
//
// Optional feature (macro REG_ARBITER_ROUND_ROBIN_EN):
//   defined   -> ties go to the requester not granted most recently
//                (requester 0 wins the first tie after reset)
//   undefined -> requester 0 always wins ties (fixed priority)
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   req0/req1         access requests
//   op0/op1           requested op: 0 = load, 1 = increment
//   data0/data1       load values (captured at grant)
//   ack0/ack1         completion acknowledges
//   busy              high whenever not in IDLE
//   ctrl_load/incr    one-cycle strobes to the shared register
//   data_out          captured data driven to the shared register

module reg_arbiter #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  op0,
    input  logic                  op1,
    input  logic [DATA_WIDTH-1:0] data0,
    input  logic [DATA_WIDTH-1:0] data1,
    output logic                  ack0,
    output logic                  ack1,
    output logic                  busy,
    output logic                  ctrl_load,
    output logic                  ctrl_incr,
    output logic [DATA_WIDTH-1:0] data_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        ACK  = 2'd2
    } state_t;

    state_t state;
    logic   winner;      // requester owning the current transaction (1 = req1)
    logic   grant1_c;    // arbitration result while in IDLE
    logic   sel_op_c;
    logic   winner_req_c;
    logic [DATA_WIDTH-1:0] sel_data_c;

`ifdef REG_ARBITER_ROUND_ROBIN_EN
    logic last1;         // requester 1 was granted most recently

    // On a tie, grant the requester that did not win last time.
    assign grant1_c = req1 & (~req0 | ~last1);
`else
    // Fixed priority: requester 0 wins every tie.
    assign grant1_c = req1 & ~req0;
`endif

    assign sel_op_c     = grant1_c ? op1 : op0;
    assign sel_data_c   = grant1_c ? data1 : data0;
    assign winner_req_c = winner ? req1 : req0;

    // FSM with registered outputs; data_out doubles as the latched data register
    // and the strobe registers carry the latched op into EXEC.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            winner    <= 1'b0;
            data_out  <= '0;
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            busy      <= 1'b0;
            ctrl_load <= 1'b0;
            ctrl_incr <= 1'b0;
`ifdef REG_ARBITER_ROUND_ROBIN_EN
            last1     <= 1'b1;
`endif
        end else begin
            ctrl_load <= 1'b0;
            ctrl_incr <= 1'b0;
            case (state)
                IDLE: begin
                    if (req0 | req1) begin
                        state     <= EXEC;
                        winner    <= grant1_c;
                        data_out  <= sel_data_c;
                        ctrl_load <= ~sel_op_c;
                        ctrl_incr <= sel_op_c;
                        busy      <= 1'b1;
`ifdef REG_ARBITER_ROUND_ROBIN_EN
                        last1     <= grant1_c;
`endif
                    end
                end
                EXEC: begin
                    state <= ACK;
                    ack0  <= ~winner;
                    ack1  <= winner;
                end
                ACK: begin
                    // Hold the ack until the winner releases its request.
                    if (!winner_req_c) begin
                        state <= IDLE;
                        ack0  <= 1'b0;
                        ack1  <= 1'b0;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    ack0  <= 1'b0;
                    ack1  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_arbiter.sv
// Testbench for reg_arbiter: directed vector table, hand-written held-ack
// sequence, and randomized traffic against a transaction-level model.
module tb_reg_arbiter;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst, req0, req1, op0, op1;
    logic [W-1:0] data0, data1;
    logic         ack0, ack1, busy, ctrl_load, ctrl_incr;
    logic [W-1:0] data_out;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    reg_arbiter #(.DATA_WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .op0(op0), .op1(op1),
        .data0(data0), .data1(data1),
        .ack0(ack0), .ack1(ack1), .busy(busy),
        .ctrl_load(ctrl_load), .ctrl_incr(ctrl_incr),
        .data_out(data_out)
    );

    // Shared register as driven by the DUT strobes.
    logic [W-1:0] dut_reg = '0;
    always @(posedge clk) begin
        if (ctrl_load)      dut_reg <= data_out;
        else if (ctrl_incr) dut_reg <= dut_reg + 1'b1;
    end

    // Transaction-level model: owner of the transaction and cycles since grant.
    int           m_owner = -1;
    int           m_age   = 0;
    logic         m_op    = 1'b0;
    logic [W-1:0] m_data  = '0;
    logic [W-1:0] m_reg   = '0;
`ifdef REG_ARBITER_ROUND_ROBIN_EN
    logic         m_last1 = 1'b1;
`endif

    function automatic int pick(input logic r0, input logic r1);
        if (r0 && r1) begin
`ifdef REG_ARBITER_ROUND_ROBIN_EN
            return m_last1 ? 0 : 1;
`else
            return 0;
`endif
        end
        return r0 ? 0 : 1;
    endfunction

    always @(posedge clk) begin
        if (m_owner >= 0 && m_age == 1)
            m_reg <= m_op ? m_reg + 1'b1 : m_data;
        if (rst) begin
            m_owner <= -1;
            m_age   <= 0;
            m_op    <= 1'b0;
            m_data  <= '0;
`ifdef REG_ARBITER_ROUND_ROBIN_EN
            m_last1 <= 1'b1;
`endif
        end else if (m_owner < 0) begin
            if (req0 || req1) begin
                m_owner <= pick(req0, req1);
                m_age   <= 1;
                m_op    <= (pick(req0, req1) == 1) ? op1 : op0;
                m_data  <= (pick(req0, req1) == 1) ? data1 : data0;
`ifdef REG_ARBITER_ROUND_ROBIN_EN
                m_last1 <= (pick(req0, req1) == 1);
`endif
            end
        end else if (m_age == 1) begin
            m_age <= 2;
        end else if (!((m_owner == 0) ? req0 : req1)) begin
            m_owner <= -1;
            m_age   <= 0;
        end
    end

    // {ack0, ack1, busy, ctrl_load, ctrl_incr, data_out}
    function automatic logic [W+4:0] dut_vec();
        return {ack0, ack1, busy, ctrl_load, ctrl_incr, data_out};
    endfunction

    function automatic logic [W+4:0] model_vec();
        logic strobe;
        strobe = (m_owner >= 0) && (m_age == 1);
        return {(m_owner == 0) && (m_age >= 2), (m_owner == 1) && (m_age >= 2),
                m_owner >= 0, strobe && !m_op, strobe && m_op, m_data};
    endfunction

    task automatic check(input string name, input logic [W+4:0] act, input logic [W+4:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h want=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        check("model", dut_vec(), model_vec());
        check("shared_reg", {5'b0, dut_reg}, {5'b0, m_reg});
    endtask

    typedef struct {
        logic         rst, req0, op0, req1, op1;
        logic [W-1:0] d0, d1;
        logic [W+4:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic q0, input logic o0, input logic [W-1:0] a0,
                                input logic q1, input logic o1, input logic [W-1:0] a1,
                                input logic [4:0] flags, input logic [W-1:0] dout);
        vec_t v;
        v.rst = r; v.req0 = q0; v.op0 = o0; v.d0 = a0;
        v.req1 = q1; v.op1 = o1; v.d1 = a1;
        v.exp = {flags, dout};
        return v;
    endfunction

    initial begin
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0; op0 = 1'b0; op1 = 1'b0;
        data0 = '0; data1 = '0;

        // flags = {ack0, ack1, busy, ctrl_load, ctrl_incr}
        vecs.push_back(mk(1, 0,0,8'h00, 0,0,8'h00, 5'b00000, 8'h00)); // 0 reset
        vecs.push_back(mk(0, 1,0,8'hA5, 0,0,8'h00, 5'b00110, 8'hA5)); // 1 load strobe
        vecs.push_back(mk(0, 1,0,8'hA5, 0,0,8'h00, 5'b10100, 8'hA5)); // 2 ack0
        vecs.push_back(mk(0, 1,0,8'hA5, 0,0,8'h00, 5'b10100, 8'hA5)); // 3 ack0 held
        vecs.push_back(mk(0, 0,0,8'hA5, 0,0,8'h00, 5'b00000, 8'hA5)); // 4 release
        vecs.push_back(mk(0, 0,0,8'h00, 1,0,8'h05, 5'b00110, 8'h05)); // 5 load 05 via req1
        vecs.push_back(mk(0, 0,0,8'h00, 1,0,8'h05, 5'b01100, 8'h05)); // 6
        vecs.push_back(mk(0, 0,0,8'h00, 0,0,8'h05, 5'b00000, 8'h05)); // 7
        vecs.push_back(mk(0, 0,0,8'h00, 1,1,8'hFF, 5'b00101, 8'hFF)); // 8 increment
        vecs.push_back(mk(0, 0,0,8'h00, 1,1,8'hFF, 5'b01100, 8'hFF)); // 9
        vecs.push_back(mk(0, 0,0,8'h00, 0,1,8'hFF, 5'b00000, 8'hFF)); // 10
        vecs.push_back(mk(0, 1,0,8'h10, 1,0,8'h20, 5'b00110, 8'h10)); // 11 tie -> 0
        vecs.push_back(mk(0, 1,0,8'h10, 1,0,8'h20, 5'b10100, 8'h10)); // 12
        vecs.push_back(mk(0, 0,0,8'h10, 1,0,8'h20, 5'b00000, 8'h10)); // 13 gap cycle
        vecs.push_back(mk(0, 0,0,8'h10, 1,0,8'h20, 5'b00110, 8'h20)); // 14 pending 1 served
        vecs.push_back(mk(0, 0,0,8'h10, 1,0,8'h20, 5'b01100, 8'h20)); // 15
        vecs.push_back(mk(0, 0,0,8'h10, 0,0,8'h20, 5'b00000, 8'h20)); // 16
        vecs.push_back(mk(0, 1,0,8'h10, 1,0,8'h20, 5'b00110, 8'h10)); // 17 repeated tie -> 0
        vecs.push_back(mk(0, 1,0,8'h10, 1,0,8'h20, 5'b10100, 8'h10)); // 18
        vecs.push_back(mk(0, 0,0,8'h10, 0,0,8'h20, 5'b00000, 8'h10)); // 19
        vecs.push_back(mk(0, 1,0,8'h11, 0,0,8'h00, 5'b00110, 8'h11)); // 20 late data change
        vecs.push_back(mk(0, 1,0,8'h22, 0,0,8'h00, 5'b10100, 8'h11)); // 21
        vecs.push_back(mk(0, 0,0,8'h22, 0,0,8'h00, 5'b00000, 8'h11)); // 22
        vecs.push_back(mk(0, 1,0,8'h33, 0,0,8'h00, 5'b00110, 8'h33)); // 23 reset mid-ACK
        vecs.push_back(mk(0, 1,0,8'h33, 0,0,8'h00, 5'b10100, 8'h33)); // 24
        vecs.push_back(mk(1, 1,0,8'h33, 0,0,8'h00, 5'b00000, 8'h00)); // 25
        vecs.push_back(mk(0, 1,0,8'h33, 0,0,8'h00, 5'b00110, 8'h33)); // 26 re-served
        vecs.push_back(mk(0, 1,0,8'h33, 0,0,8'h00, 5'b10100, 8'h33)); // 27
        vecs.push_back(mk(0, 0,0,8'h33, 0,0,8'h00, 5'b00000, 8'h33)); // 28
        vecs.push_back(mk(0, 1,0,8'h44, 0,0,8'h00, 5'b00110, 8'h44)); // 29 req1 drops pre-grant
        vecs.push_back(mk(0, 1,0,8'h44, 1,1,8'h99, 5'b10100, 8'h44)); // 30
        vecs.push_back(mk(0, 1,0,8'h44, 0,1,8'h99, 5'b10100, 8'h44)); // 31
        vecs.push_back(mk(0, 0,0,8'h44, 0,1,8'h99, 5'b00000, 8'h44)); // 32
        vecs.push_back(mk(0, 0,0,8'h44, 0,1,8'h99, 5'b00000, 8'h44)); // 33 nothing served
`ifdef REG_ARBITER_ROUND_ROBIN_EN
        vecs.push_back(mk(0, 1,0,8'h55, 1,0,8'h66, 5'b00110, 8'h66)); // 34 tie after 0 -> 1
        vecs.push_back(mk(0, 1,0,8'h55, 1,0,8'h66, 5'b01100, 8'h66)); // 35
        vecs.push_back(mk(0, 0,0,8'h55, 0,0,8'h66, 5'b00000, 8'h66)); // 36
`else
        vecs.push_back(mk(0, 1,0,8'h55, 1,0,8'h66, 5'b00110, 8'h55)); // 34 tie -> 0 again
        vecs.push_back(mk(0, 1,0,8'h55, 1,0,8'h66, 5'b10100, 8'h55)); // 35
        vecs.push_back(mk(0, 0,0,8'h55, 0,0,8'h66, 5'b00000, 8'h55)); // 36
`endif

        @(negedge clk);
        foreach (vecs[i]) begin
            rst = vecs[i].rst; req0 = vecs[i].req0; op0 = vecs[i].op0; data0 = vecs[i].d0;
            req1 = vecs[i].req1; op1 = vecs[i].op1; data1 = vecs[i].d1;
            step();
            check($sformatf("vec%0d", i), dut_vec(), vecs[i].exp);
            if (i == 10) check("incr_reg_06", {5'b0, dut_reg}, {5'b0, 8'h06});
            if (i == 22) check("late_change_reg_11", {5'b0, dut_reg}, {5'b0, 8'h11});
        end

        // Held ack on requester 1 with requester 0 pending.
        req1 = 1'b1; op1 = 1'b1; data1 = 8'h77;
        step();
        check("held_incr", dut_vec(), {5'b00101, 8'h77});
        req0 = 1'b1; op0 = 1'b0; data0 = 8'h88;
        step();
        check("held_ack1", dut_vec(), {5'b01100, 8'h77});
        for (int k = 0; k < 5; k++) begin
            step();
            check($sformatf("held_ack1_%0d", k), dut_vec(), {5'b01100, 8'h77});
        end
        req1 = 1'b0;
        step();
        check("held_release", dut_vec(), {5'b00000, 8'h77});
        step();
        check("pending_req0_grant", dut_vec(), {5'b00110, 8'h88});
        step();
        check("pending_req0_ack", dut_vec(), {5'b10100, 8'h88});
        req0 = 1'b0;
        step();
        check("pending_req0_done", dut_vec(), {5'b00000, 8'h88});

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 199) == 0);
            if (req0 && ack0)                     req0 = $urandom_range(0, 1) == 0;
            else if (req0 && $urandom_range(0, 19) == 0) req0 = 1'b0;
            else if (!req0 && $urandom_range(0, 2) == 0) req0 = 1'b1;
            if (req1 && ack1)                     req1 = $urandom_range(0, 1) == 0;
            else if (req1 && $urandom_range(0, 19) == 0) req1 = 1'b0;
            else if (!req1 && $urandom_range(0, 2) == 0) req1 = 1'b1;
            if ($urandom_range(0, 3) == 0) begin
                op0 = 1'($urandom_range(0, 1)); data0 = W'($urandom_range(0, 255));
            end
            if ($urandom_range(0, 3) == 0) begin
                op1 = 1'($urandom_range(0, 1)); data1 = W'($urandom_range(0, 255));
            end
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reg_arbiter.md
REG_ARBITER -- requirements
Module: reg_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, the width of the shared register's data path.
REQ-002 The block SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 The block SHALL have ports req0/req1  input  1 each  access request from requester 0/1.
REQ-005 The block SHALL have ports op0/op1  input  1 each  requested operation: 0 = load, 1 = increment.
REQ-006 The block SHALL have ports data0/data1  input  DATA_WIDTH each  load value from requester 0/1; ignored for increment.
REQ-007 The block SHALL have ports ack0/ack1  output  1 each  completion acknowledge to requester 0/1.
REQ-008 The block SHALL have port busy  output  1  high in any state other than IDLE.
REQ-009 The block SHALL have ports ctrl_load/ctrl_incr  output  1 each  load/increment strobes to the shared register.
REQ-010 The block SHALL have port data_out  output  DATA_WIDTH  value driven to the shared register's data input.

Function
REQ-011 The FSM SHALL have the states IDLE, EXEC, ACK.
REQ-012 In IDLE with at least one reqN high, the block SHALL pick a winner, latch its op and data into internal registers, and enter EXEC on the next edge.
REQ-013 In EXEC, lasting exactly one cycle, the block SHALL assert exactly one of ctrl_load (latched op=0) or ctrl_incr (latched op=1), drive data_out with the latched data, then enter ACK.
REQ-014 In ACK, the block SHALL hold ackN high for the winner only, and SHALL leave ACK for IDLE on the first edge where the winner's reqN is low (four-phase handshake).
REQ-015 Request-to-strobe latency SHALL be exactly 1 cycle; strobe-to-ack latency SHALL be exactly 1 cycle.
REQ-016 Requesters SHALL hold op/data stable only while req is high and unacknowledged; the values latched at grant are used, and later changes to op/data SHALL have no effect.
REQ-017 ctrl_load and ctrl_incr SHALL never be high together, and SHALL be low outside EXEC.
REQ-018 data_out SHALL hold the last latched data outside EXEC; it SHALL be 0 after reset.
REQ-019 A request from the losing requester SHALL be held pending, without ack, and SHALL be served in the first IDLE cycle after the current transaction.
REQ-020 A reqN that drops before grant SHALL be ignored, with no strobe and no ack.
REQ-021 The minimum transaction length SHALL be 3 cycles (IDLE, EXEC, ACK); back-to-back grants SHALL be separated by at least one IDLE cycle.
REQ-022 All outputs SHALL be registered, or decoded only from state registers; there SHALL be no combinational path from any input to any output.

Reset
REQ-023 When rst is high at a rising clk edge, the block SHALL enter IDLE, clear its latched op/data, and set the priority pointer so that requester 0 wins the next tie.
REQ-024 During and after reset, the outputs SHALL be 0: ack0, ack1, busy, ctrl_load, ctrl_incr, and data_out.
REQ-025 A reset during EXEC or ACK SHALL abort the transaction: any strobe already issued stands, no ack is issued, and the pending request is re-arbitrated after reset.

Configuration
REQ-026 With macro REG_ARBITER_ROUND_ROBIN_EN defined, ties SHALL go to the requester not granted most recently; after reset, requester 0 wins the first tie.
REQ-027 Without REG_ARBITER_ROUND_ROBIN_EN defined, requester 0 SHALL always win ties (fixed priority), and the priority pointer logic SHALL be absent.

Verification
REQ-028 Scenario single load: reset, then req0=1, op0=0, data0=8'hA5 -> ctrl_load high for one cycle with data_out=8'hA5 one cycle later; ack0 high the next cycle; ack0 drops one cycle after req0 is released.
REQ-029 Scenario increment: req1=1, op1=1 -> ctrl_incr high for exactly one cycle; ctrl_load stays 0; ack1 follows; the shared register goes 8'h05 -> 8'h06.
REQ-030 Scenario tie, round-robin on: req0 and req1 raised together and held, with each requester releasing after its ack -> grants go 0, then 1, and the next repeated tie goes to 0; with the macro off -> 0 wins every tie.
REQ-031 Scenario late data change: change data0 from 8'h11 to 8'h22 in the EXEC cycle -> data_out=8'h11 and the register loads 8'h11.
REQ-032 Scenario reset mid-ACK: assert rst while ack0=1 -> next cycle all outputs are 0 and state is IDLE; req0 still high after reset -> re-served with a fresh strobe and ack.
REQ-033 Scenario held ack: keep req1 high for 5 cycles after ack1 -> ack1 and busy stay high for those cycles; a pending req0 is not granted until req1 drops.
